// File: rtl/implication_window_monitor_pkg.sv
// Shared constants, counter type and popcount helper for the implication window monitor.
package monitor_pkg;

  localparam int MAX_DLY_HI = 31;
  localparam int CNT_W_DEF  = 16;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  function automatic logic [5:0] popcount(input logic [MAX_DLY_HI:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i <= MAX_DLY_HI; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/implication_window_monitor_if.sv
// Per-channel stimulus and verdict bundle of the monitor; master drives the property inputs.
interface implication_window_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);

  logic [NUM_CH-1:0]       antecedent_in;
  logic [NUM_CH-1:0]       consequent_in;
  logic [NUM_CH-1:0]       disable_in;
  logic [NUM_CH-1:0]       pass_pulse_out;
  logic [NUM_CH-1:0]       fail_pulse_out;
  logic [NUM_CH-1:0]       fail_seen_out;
  logic [NUM_CH*CNT_W-1:0] pass_cnt_out;
  logic [NUM_CH*CNT_W-1:0] fail_cnt_out;

  modport master (
    output antecedent_in, consequent_in, disable_in,
    input  pass_pulse_out, fail_pulse_out, fail_seen_out, pass_cnt_out, fail_cnt_out
  );

  modport slave (
    input  antecedent_in, consequent_in, disable_in,
    output pass_pulse_out, fail_pulse_out, fail_seen_out, pass_cnt_out, fail_cnt_out
  );

endinterface

// File: rtl/implication_window_monitor_tracker.sv
// One channel of the monitor: pending-attempt vector, window hit/fail logic, counters, sticky flag.
// Optional IMPLICATION_WINDOW_MONITOR_SVA_EN adds equivalent concurrent assertions.
module implication_tracker
  import monitor_pkg::*;
#(
  parameter int DLY_LO = 1,
  parameter int DLY_HI = 3,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clr_in,
  input  logic             ant_in,
  input  logic             cons_in,
  input  logic             dis_in,
  output logic             pass_pulse_out,
  output logic             fail_pulse_out,
  output logic             fail_seen_out,
  output logic [CNT_W-1:0] pass_cnt_out,
  output logic [CNT_W-1:0] fail_cnt_out
);

  localparam int SUM_W = CNT_W + 6;
  localparam logic [SUM_W-1:0] SAT = (SUM_W'(1) << CNT_W) - SUM_W'(1);

  logic [DLY_HI:1]     p_q, p_d;
  logic [DLY_HI:0]     a, hit;
  logic [MAX_DLY_HI:0] hit_ext;
  logic                fail;
  logic [5:0]          n_pass;
  logic [CNT_W-1:0]    pass_base, fail_base;
  logic [SUM_W-1:0]    pass_sum, fail_sum;
  logic                pass_pulse_q, pass_pulse_d;
  logic                fail_pulse_q, fail_pulse_d;
  logic                fail_seen_q, fail_seen_d;
  logic [CNT_W-1:0]    pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]    fail_cnt_q, fail_cnt_d;

  always_comb begin
    a       = '0;
    hit     = '0;
    hit_ext = '0;
    p_d     = '0;
    a[0]    = ant_in & ~dis_in;
    for (int k = 1; k <= DLY_HI; k++) begin
      a[k] = p_q[k];
    end
    for (int k = 0; k <= DLY_HI; k++) begin
      if (k >= DLY_LO) hit[k] = a[k] & cons_in;
    end
    fail = a[DLY_HI] & ~cons_in;
    // disable aborts every attempt in flight without a verdict
    if (dis_in) begin
      hit  = '0;
      fail = 1'b0;
    end else begin
      for (int k = 0; k < DLY_HI; k++) begin
        p_d[k+1] = a[k] & ~hit[k];
      end
    end
    hit_ext[DLY_HI:0] = hit;
    n_pass            = popcount(hit_ext);

    // a coincident clear still counts this cycle's event
    pass_base = clr_in ? '0 : pass_cnt_q;
    fail_base = clr_in ? '0 : fail_cnt_q;
    pass_sum  = SUM_W'(pass_base) + SUM_W'(n_pass);
    fail_sum  = SUM_W'(fail_base) + SUM_W'(fail);
    pass_cnt_d = (pass_sum > SAT) ? SAT[CNT_W-1:0] : pass_sum[CNT_W-1:0];
    fail_cnt_d = (fail_sum > SAT) ? SAT[CNT_W-1:0] : fail_sum[CNT_W-1:0];
    fail_seen_d  = (fail_seen_q & ~clr_in) | fail;
    pass_pulse_d = |hit;
    fail_pulse_d = fail;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      p_q          <= '0;
      pass_pulse_q <= 1'b0;
      fail_pulse_q <= 1'b0;
      fail_seen_q  <= 1'b0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
    end else begin
      p_q          <= p_d;
      pass_pulse_q <= pass_pulse_d;
      fail_pulse_q <= fail_pulse_d;
      fail_seen_q  <= fail_seen_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
    end
  end

  assign pass_pulse_out = pass_pulse_q;
  assign fail_pulse_out = fail_pulse_q;
  assign fail_seen_out  = fail_seen_q;
  assign pass_cnt_out   = pass_cnt_q;
  assign fail_cnt_out   = fail_cnt_q;

`ifdef IMPLICATION_WINDOW_MONITOR_SVA_EN
  a_impl: assert property (@(posedge clk_in) disable iff (rst_in || dis_in)
    ant_in |-> ##[DLY_LO:DLY_HI] cons_in);

  a_fail_match: assert property (@(posedge clk_in) disable iff (rst_in)
    !$past(rst_in) |-> (fail_pulse_q == $past(a[DLY_HI] & ~cons_in & ~dis_in)));
`endif

endmodule

// File: rtl/implication_window_monitor.sv
// Multi-channel window-implication monitor: parameter checks and per-channel tracker array.
// Optional IMPLICATION_WINDOW_MONITOR_SVA_EN enables assertion cross-checks in each tracker.
module implication_window_monitor
  import monitor_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DLY_LO = 1,
  parameter int DLY_HI = 3,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic clk_in,
  input logic rst_in,
  input logic clr_in,
  implication_window_monitor_if.slave mon
);

  if (NUM_CH < 1 || DLY_LO < 0 || DLY_LO > DLY_HI || DLY_HI < 1 || DLY_HI > MAX_DLY_HI) begin : g_bad_param
    $error("implication_window_monitor: illegal NUM_CH/DLY_LO/DLY_HI combination");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    implication_tracker #(
      .DLY_LO (DLY_LO),
      .DLY_HI (DLY_HI),
      .CNT_W  (CNT_W)
    ) u_trk (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .clr_in         (clr_in),
      .ant_in         (mon.antecedent_in[i]),
      .cons_in        (mon.consequent_in[i]),
      .dis_in         (mon.disable_in[i]),
      .pass_pulse_out (mon.pass_pulse_out[i]),
      .fail_pulse_out (mon.fail_pulse_out[i]),
      .fail_seen_out  (mon.fail_seen_out[i]),
      .pass_cnt_out   (mon.pass_cnt_out[i*CNT_W +: CNT_W]),
      .fail_cnt_out   (mon.fail_cnt_out[i*CNT_W +: CNT_W])
    );
  end

endmodule
